pipe_stage_latch: RTL and testbench
===================================

PIPE_STAGE_LATCH -- requirements
Module: pipe_stage_latch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the oIn/dIn/oOut/dOut payloads.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, width of the rdIn/rdOut destination-register field.
REQ-003 SHALL have parameter GATE_BUBBLES, default 1; when 1, control and rd outputs are forced to 0 while outValid=0.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-007 inValid  in  1  upstream stage presents a valid instruction.
REQ-008 inReady  out  1  this stage can accept an instruction this cycle.
REQ-009 oIn, dIn  in  DATA_WIDTH each  ALU result and store data.
REQ-010 rdIn  in  REG_ADDR_WIDTH  destination register.
REQ-011 wMemIn, wRegIn, lwIn  in  1 each  memory write, register write and load flags.
REQ-012 flush  in  1  synchronous kill of all held instructions.
REQ-013 outValid  out  1  output entry holds a valid instruction.
REQ-014 outReady  in  1  downstream stage accepts the output entry this cycle.
REQ-015 oOut, dOut  out  DATA_WIDTH each; rdOut  out  REG_ADDR_WIDTH; wMemOut, wRegOut, lwOut  out  1 each: the output entry's fields.
REQ-016 occupancy  out  2  number of valid entries held (0..2).

Function
REQ-017 SHALL hold two entries: main (drives outputs) and skid; each entry stores all payload fields plus a valid bit.
REQ-018 inReady SHALL equal NOT skid.valid, driven from a register with no combinational path from outReady.
REQ-019 Input transfer SHALL occur when inValid=1 and inReady=1; output transfer when outValid=1 and outReady=1.
REQ-020 outValid SHALL equal main.valid; occupancy SHALL equal main.valid + skid.valid.
REQ-021 Empty stage with an input transfer: main SHALL load the input; outValid=1 on the next cycle (latency 1).
REQ-022 Main valid, skid empty, simultaneous input and output transfer: main SHALL load the input; occupancy stays 1.
REQ-023 Main valid, skid empty, input transfer, no output transfer: skid SHALL load the input; inReady=0 on the next cycle.
REQ-024 Main valid, skid empty, output transfer, no input: main.valid SHALL clear.
REQ-025 Skid valid with an output transfer: main SHALL load skid contents and skid.valid SHALL clear; no input is accepted in that cycle.
REQ-026 Skid valid without an output transfer: all state SHALL hold.
REQ-027 Ordering SHALL be strictly FIFO; no entry is lost or duplicated.
REQ-028 flush=1 at a clock edge SHALL clear main.valid, skid.valid and the stored wMem/wReg/lw bits of both entries, and SHALL discard any same-cycle input; flush overrides all transfers.
REQ-029 Data fields (o, d, rd) SHALL NOT be cleared by flush; they hold prior values.
REQ-030 GATE_BUBBLES=1: wMemOut, wRegOut, lwOut and rdOut SHALL be 0 whenever outValid=0. GATE_BUBBLES=0: they SHALL show the stored main fields unconditionally.
REQ-031 oOut and dOut SHALL always show the stored main fields, gated or not.

Reset
REQ-032 reset=0 SHALL immediately, without a clock edge, clear both valid bits and all stored fields to 0: outValid=0, occupancy=0, all data and control outputs 0, inReady=1.
REQ-033 Reset asserted mid-operation SHALL discard both entries; after release the first accepted input SHALL appear after one cycle, per REQ-021.

Verification
REQ-034 Pass-through: outReady=1; drive o=0x0000_00A5, rd=7, wReg=1 for one cycle -> next cycle outValid=1, oOut=0xA5, rdOut=7, wRegOut=1; occupancy 1 then 0.
REQ-035 Backpressure: outReady=0; send A then B -> occupancy=2, inReady=0; raise outReady -> A then B on consecutive cycles, inReady=1 one cycle after A leaves.
REQ-036 Flush: two entries held with wMem=1; pulse flush with inValid=1 and input C -> next cycle occupancy=0, wMemOut=0, rdOut=0, C never appears.
REQ-037 Async reset: assert reset=0 between clock edges with occupancy=2 -> outputs 0 and inReady=1 before the next edge.
REQ-038 Streaming: 100 random transactions with random inValid/outReady -> output sequence equals input sequence, with no inReady/outValid protocol violation.
REQ-039 GATE_BUBBLES=0 build: after the output drains, with stored wReg=1 -> wRegOut=1 while outValid=0.

Source files
------------

// File: rtl/pipe_stage_latch.sv
// Purpose: two-entry pipeline stage register (main + skid) with flush and optional bubble gating.
// Latency: one cycle from input transfer to outValid when the stage is empty.
// Backpressure: inReady is a registered !skid.valid, so it has no combinational path from outReady.
module pipe_stage_latch #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int GATE_BUBBLES   = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [DATA_WIDTH-1:0]     oIn,
    input  logic [DATA_WIDTH-1:0]     dIn,
    input  logic [REG_ADDR_WIDTH-1:0] rdIn,
    input  logic                      wMemIn,
    input  logic                      wRegIn,
    input  logic                      lwIn,
    input  logic                      flush,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [DATA_WIDTH-1:0]     oOut,
    output logic [DATA_WIDTH-1:0]     dOut,
    output logic [REG_ADDR_WIDTH-1:0] rdOut,
    output logic                      wMemOut,
    output logic                      wRegOut,
    output logic                      lwOut,
    output logic [1:0]                occupancy
);

    // One held instruction: payload plus its control flags.
    typedef struct packed {
        logic [DATA_WIDTH-1:0]     o;
        logic [DATA_WIDTH-1:0]     d;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      wmem;
        logic                      wreg;
        logic                      lw;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;

    entry_t in_ent;
    logic   in_xfer;
    logic   out_xfer;
    logic   gate_bubble;

    // Pack the upstream fields into one entry.
    always_comb begin
        in_ent      = '0;
        in_ent.o    = oIn;
        in_ent.d    = dIn;
        in_ent.rd   = rdIn;
        in_ent.wmem = wMemIn;
        in_ent.wreg = wRegIn;
        in_ent.lw   = lwIn;
    end

    // The skid valid bit alone decides readiness; it is a flop output.
    assign inReady  = ~skid_vld_q;
    assign outValid = main_vld_q;
    assign in_xfer  = inValid & ~skid_vld_q;
    assign out_xfer = main_vld_q & outReady;

    // Next-state selection: flush wins, then skid refill, then accept/drain.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;

        if (flush) begin
            // Kill both entries; payload data is left in place, only flags drop.
            main_vld_d  = 1'b0;
            skid_vld_d  = 1'b0;
            main_d.wmem = 1'b0;
            main_d.wreg = 1'b0;
            main_d.lw   = 1'b0;
            skid_d.wmem = 1'b0;
            skid_d.wreg = 1'b0;
            skid_d.lw   = 1'b0;
        end else if (skid_vld_q) begin
            // Skid full: input is blocked; the older skid entry moves up when main leaves.
            if (out_xfer) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!main_vld_q || out_xfer) begin
                // Main is free (or being freed this cycle): new entry goes straight to main.
                main_d     = in_ent;
                main_vld_d = 1'b1;
            end else begin
                // Main is stalled: park the new entry in the skid.
                skid_d     = in_ent;
                skid_vld_d = 1'b1;
            end
        end else if (out_xfer) begin
            main_vld_d = 1'b0;
        end
    end

    // State registers with asynchronous clear of valid bits and all fields.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    // Bubble gating hides stale control and rd fields from downstream when enabled.
    assign gate_bubble = (GATE_BUBBLES != 0) && !main_vld_q;

    assign oOut      = main_q.o;
    assign dOut      = main_q.d;
    assign rdOut     = gate_bubble ? '0 : main_q.rd;
    assign wMemOut   = gate_bubble ? 1'b0 : main_q.wmem;
    assign wRegOut   = gate_bubble ? 1'b0 : main_q.wreg;
    assign lwOut     = gate_bubble ? 1'b0 : main_q.lw;
    assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: tb/tb_pipe_stage_latch.sv
module tb_pipe_stage_latch;

    logic        clock;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] oIn, dIn;
    logic [4:0]  rdIn;
    logic        wMemIn, wRegIn, lwIn;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [31:0] oOut, dOut;
    logic [4:0]  rdOut;
    logic        wMemOut, wRegOut, lwOut;
    logic [1:0]  occupancy;

    logic        ng_inReady, ng_outValid;
    logic [31:0] ng_oOut, ng_dOut;
    logic [4:0]  ng_rdOut;
    logic        ng_wMemOut, ng_wRegOut, ng_lwOut;
    logic [1:0]  ng_occupancy;

    int total = 0;
    int bad   = 0;

    pipe_stage_latch #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .GATE_BUBBLES(1)) dut (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
        .oIn(oIn), .dIn(dIn), .rdIn(rdIn), .wMemIn(wMemIn), .wRegIn(wRegIn), .lwIn(lwIn),
        .flush(flush), .outValid(outValid), .outReady(outReady),
        .oOut(oOut), .dOut(dOut), .rdOut(rdOut), .wMemOut(wMemOut), .wRegOut(wRegOut),
        .lwOut(lwOut), .occupancy(occupancy)
    );

    pipe_stage_latch #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .GATE_BUBBLES(0)) dut_ng (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(ng_inReady),
        .oIn(oIn), .dIn(dIn), .rdIn(rdIn), .wMemIn(wMemIn), .wRegIn(wRegIn), .lwIn(lwIn),
        .flush(flush), .outValid(ng_outValid), .outReady(outReady),
        .oOut(ng_oOut), .dOut(ng_dOut), .rdOut(ng_rdOut), .wMemOut(ng_wMemOut), .wRegOut(ng_wRegOut),
        .lwOut(ng_lwOut), .occupancy(ng_occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] o, input logic [31:0] d, input logic [4:0] rd,
                         input logic wm, input logic wr, input logic l);
        inValid = v; oIn = o; dIn = d; rdIn = rd; wMemIn = wm; wRegIn = wr; lwIn = l;
    endtask

    task automatic test_reset();
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL rst_outValid: got %0h want 0", outValid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL rst_inReady: got %0h want 1", inReady); end
        total++; if ({oOut, dOut, rdOut, wMemOut, wRegOut, lwOut} !== 72'd0) begin bad++; $display("FAIL rst_fields: got %0h want 0", {oOut, dOut, rdOut, wMemOut, wRegOut, lwOut}); end
        total++; if ({ng_oOut, ng_dOut, ng_rdOut, ng_wMemOut, ng_wRegOut, ng_lwOut} !== 72'd0) begin bad++; $display("FAIL rst_fields_ng: got %0h want 0", {ng_oOut, ng_dOut, ng_rdOut, ng_wMemOut, ng_wRegOut, ng_lwOut}); end
    endtask

    task automatic test_passthrough();
        outReady = 1'b1;
        drive(1'b1, 32'h0000_00A5, 32'h0, 5'd7, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        total++; if (outValid !== 1'b1) begin bad++; $display("FAIL pt_outValid: got %0h want 1", outValid); end
        total++; if (oOut !== 32'hA5) begin bad++; $display("FAIL pt_oOut: got %0h want a5", oOut); end
        total++; if (rdOut !== 5'd7) begin bad++; $display("FAIL pt_rdOut: got %0d want 7", rdOut); end
        total++; if (wRegOut !== 1'b1) begin bad++; $display("FAIL pt_wRegOut: got %0h want 1", wRegOut); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL pt_occ1: got %0d want 1", occupancy); end
        step();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL pt_occ0: got %0d want 0", occupancy); end
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL pt_drained: got %0h want 0", outValid); end
        total++; if (rdOut !== 5'd0 || wRegOut !== 1'b0) begin bad++; $display("FAIL pt_gated: got rd=%0d wreg=%0h want 0/0", rdOut, wRegOut); end
        total++; if (oOut !== 32'hA5) begin bad++; $display("FAIL pt_oOut_hold: got %0h want a5", oOut); end
        // Ungated build keeps showing the stored flags after draining.
        total++; if (ng_outValid !== 1'b0 || ng_wRegOut !== 1'b1) begin bad++; $display("FAIL ng_wRegOut: got v=%0h wreg=%0h want 0/1", ng_outValid, ng_wRegOut); end
        total++; if (ng_rdOut !== 5'd7) begin bad++; $display("FAIL ng_rdOut: got %0d want 7", ng_rdOut); end
    endtask

    task automatic test_backpressure();
        outReady = 1'b0;
        drive(1'b1, 32'h111, 32'hD11, 5'd1, 1'b0, 1'b1, 1'b0);
        step();
        total++; if (occupancy !== 2'd1 || inReady !== 1'b1) begin bad++; $display("FAIL bp_A: got occ=%0d rdy=%0h want 1/1", occupancy, inReady); end
        drive(1'b1, 32'h222, 32'hD22, 5'd2, 1'b0, 1'b1, 1'b0);
        step();
        total++; if (occupancy !== 2'd2 || inReady !== 1'b0) begin bad++; $display("FAIL bp_full: got occ=%0d rdy=%0h want 2/0", occupancy, inReady); end
        total++; if (oOut !== 32'h111) begin bad++; $display("FAIL bp_headA: got %0h want 111", oOut); end
        // Offer X while full: it must never be taken.
        drive(1'b1, 32'h999, 32'hD99, 5'd9, 1'b1, 1'b1, 1'b1);
        step();
        total++; if (occupancy !== 2'd2 || oOut !== 32'h111) begin bad++; $display("FAIL bp_hold: got occ=%0d o=%0h want 2/111", occupancy, oOut); end
        outReady = 1'b1;
        step();
        inValid = 1'b0;
        total++; if (oOut !== 32'h222 || rdOut !== 5'd2 || outValid !== 1'b1) begin bad++; $display("FAIL bp_headB: got o=%0h rd=%0d v=%0h want 222/2/1", oOut, rdOut, outValid); end
        total++; if (inReady !== 1'b1 || occupancy !== 2'd1) begin bad++; $display("FAIL bp_ready: got rdy=%0h occ=%0d want 1/1", inReady, occupancy); end
        step();
        total++; if (occupancy !== 2'd0 || outValid !== 1'b0) begin bad++; $display("FAIL bp_empty: got occ=%0d v=%0h want 0/0", occupancy, outValid); end
    endtask

    task automatic test_flush();
        outReady = 1'b0;
        drive(1'b1, 32'h333, 32'hD33, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h444, 32'hD44, 5'd4, 1'b1, 1'b0, 1'b0);
        step();
        total++; if (occupancy !== 2'd2 || wMemOut !== 1'b1) begin bad++; $display("FAIL fl_pre: got occ=%0d wmem=%0h want 2/1", occupancy, wMemOut); end
        flush = 1'b1;
        drive(1'b1, 32'hCCC, 32'hDCC, 5'd12, 1'b1, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        inValid = 1'b0;
        total++; if (occupancy !== 2'd0 || outValid !== 1'b0 || inReady !== 1'b1) begin bad++; $display("FAIL fl_occ: got occ=%0d v=%0h rdy=%0h want 0/0/1", occupancy, outValid, inReady); end
        total++; if (wMemOut !== 1'b0 || rdOut !== 5'd0) begin bad++; $display("FAIL fl_gated: got wmem=%0h rd=%0d want 0/0", wMemOut, rdOut); end
        total++; if (ng_wMemOut !== 1'b0 || ng_rdOut !== 5'd3 || ng_oOut !== 32'h333) begin bad++; $display("FAIL fl_ng: got wmem=%0h rd=%0d o=%0h want 0/3/333", ng_wMemOut, ng_rdOut, ng_oOut); end
        outReady = 1'b1;
        step();
        total++; if (occupancy !== 2'd0 || outValid !== 1'b0) begin bad++; $display("FAIL fl_noC: got occ=%0d v=%0h want 0/0", occupancy, outValid); end
        // Flush with an input that would otherwise be accepted.
        outReady = 1'b0;
        drive(1'b1, 32'h555, 32'hD55, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h5C5, 32'hDC5, 5'd6, 1'b1, 1'b0, 1'b0);
        step();
        flush = 1'b0;
        inValid = 1'b0;
        total++; if (occupancy !== 2'd0 || oOut !== 32'h555) begin bad++; $display("FAIL fl_discard: got occ=%0d o=%0h want 0/555", occupancy, oOut); end
    endtask

    task automatic test_async_reset();
        outReady = 1'b0;
        drive(1'b1, 32'h0F1, 32'hD1, 5'd9, 1'b0, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'h0F2, 32'hD2, 5'd10, 1'b0, 1'b1, 1'b1);
        step();
        inValid = 1'b0;
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL ar_pre: got occ=%0d want 2", occupancy); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (outValid !== 1'b0 || occupancy !== 2'd0 || inReady !== 1'b1) begin bad++; $display("FAIL ar_state: got v=%0h occ=%0d rdy=%0h want 0/0/1", outValid, occupancy, inReady); end
        total++; if ({oOut, dOut, rdOut, wMemOut, wRegOut, lwOut} !== 72'd0) begin bad++; $display("FAIL ar_fields: got %0h want 0", {oOut, dOut, rdOut, wMemOut, wRegOut, lwOut}); end
        total++; if ({ng_oOut, ng_dOut, ng_rdOut, ng_wMemOut, ng_wRegOut, ng_lwOut} !== 72'd0) begin bad++; $display("FAIL ar_fields_ng: got %0h want 0", {ng_oOut, ng_dOut, ng_rdOut, ng_wMemOut, ng_wRegOut, ng_lwOut}); end
        #1;
        reset = 1'b1;
        outReady = 1'b1;
        drive(1'b1, 32'h777, 32'hD77, 5'd11, 1'b0, 1'b1, 1'b0);
        step();
        inValid = 1'b0;
        total++; if (outValid !== 1'b1 || oOut !== 32'h777 || rdOut !== 5'd11 || occupancy !== 2'd1) begin bad++; $display("FAIL ar_first: got v=%0h o=%0h rd=%0d occ=%0d want 1/777/11/1", outValid, oOut, rdOut, occupancy); end
        step();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL ar_drain: got occ=%0d want 0", occupancy); end
    endtask

    task automatic test_stream();
        logic [71:0] q[$];
        logic [71:0] exp_ent;
        int sent = 0;
        int got  = 0;
        logic in_f, out_f;
        inValid = 1'b0;
        flush   = 1'b0;
        for (int cyc = 0; cyc < 4000 && got < 100; cyc++) begin
            if (!inValid && sent < 100 && $urandom_range(0, 3) != 0)
                drive(1'b1, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            outReady = ($urandom_range(0, 2) != 0);
            total++; if (inReady !== (occupancy != 2'd2)) begin bad++; $display("FAIL st_inReady: got %0h occ=%0d cyc=%0d", inReady, occupancy, cyc); end
            total++; if (outValid !== (occupancy != 2'd0)) begin bad++; $display("FAIL st_outValid: got %0h occ=%0d cyc=%0d", outValid, occupancy, cyc); end
            in_f  = inValid && inReady;
            out_f = outValid && outReady;
            if (out_f) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL st_spurious: got %0h want nothing", oOut);
                end else begin
                    exp_ent = q.pop_front();
                    if ({oOut, dOut, rdOut, wMemOut, wRegOut, lwOut} !== exp_ent) begin
                        bad++; $display("FAIL st_order: got %0h want %0h", {oOut, dOut, rdOut, wMemOut, wRegOut, lwOut}, exp_ent);
                    end
                end
                got++;
            end
            if (in_f) begin
                q.push_back({oIn, dIn, rdIn, wMemIn, wRegIn, lwIn});
                sent++;
            end
            step();
            if (in_f) inValid = 1'b0;
        end
        inValid = 1'b0;
        total++; if (got != 100 || sent != 100 || q.size() != 0) begin bad++; $display("FAIL st_count: got sent=%0d recv=%0d left=%0d want 100/100/0", sent, got, q.size()); end
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        outReady = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        test_reset();
        step();
        @(negedge clock);
        reset = 1'b1;
        step();
        test_passthrough();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
